// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared types and defaults for the PISO transmitter.
// Parity frames are enabled with the PISO_TX_PARITY_EN macro.
package piso_tx_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR
  } state_t;

endpackage

// File: rtl/piso_tx_if.sv
// piso_tx_if: parallel load / serial out bundle of the PISO transmitter.
// master drives words in, slave is the transmitter.
interface piso_tx_if
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] din;
  logic             load;
  logic             flush;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output din, load, flush,
    input  ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  din, load, flush,
    output ready, sout, sout_valid, busy, done
  );

endinterface

// File: rtl/piso_tx_bitcnt.sv
// piso_tx_bitcnt: saturating up-counter 0..MAX-1 with clear and enable.
// tc flags the terminal value; the count never wraps.
module piso_tx_bitcnt #(
  parameter int MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  output logic [$clog2(MAX)-1:0] cnt,
  output logic                   tc
);

  localparam int CW = $clog2(MAX);
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with load/ready handshake.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic      clk,
  input logic      rst,
  piso_tx_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] PEN = CW'(WIDTH - 2);
`ifdef PISO_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             in_shift;
  logic             first_bit;
  logic             next_bit;
  logic             sout;
  logic             sout_valid;
  logic             done;

  assign bus.ready      = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.sout       = sout;
  assign bus.sout_valid = sout_valid;
  assign bus.done       = done;

  assign accept    = bus.load & (state == IDLE);
  assign in_shift  = (state == SHIFT);
  assign first_bit = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
  assign next_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

  piso_tx_bitcnt #(
    .MAX (WIDTH)
  ) u_bitcnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (in_shift & ~bus.flush),
    .cnt (cnt),
    .tc  (tc)
  );

  // first bit leaves at acceptance, so sreg holds only the remaining bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (accept) begin
      sreg <= MSB_FIRST ? (bus.din << 1) : (bus.din >> 1);
    end else if (in_shift) begin
      sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
    end
  end

`ifdef PISO_TX_PARITY_EN
  logic par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^bus.din;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.load) begin
            state      <= SHIFT;
            sout       <= first_bit;
            sout_valid <= 1'b1;
          end else begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.flush) begin
            state      <= IDLE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
          end else if (tc) begin
`ifdef PISO_TX_PARITY_EN
            state      <= PAR;
            sout       <= par;
            sout_valid <= 1'b1;
            done       <= 1'b1;
`else
            state      <= IDLE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
`endif
          end else begin
            sout       <= next_bit;
            sout_valid <= 1'b1;
            done       <= ~PAR_EN & (cnt == PEN);
          end
        end
`ifdef PISO_TX_PARITY_EN
        PAR: begin
          state      <= IDLE;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
        end
`endif
        default: begin
          state      <= IDLE;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: drives an MSB-first and an LSB-first transmitter in lockstep
// and compares both against a queue-based frame model every cycle.
module tb_piso_tx;

  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + PAR;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         load = 1'b0;
  logic         flush = 1'b0;

  int errors = 0;
  int checks = 0;

  bit q_m[$];
  bit q_l[$];

  piso_tx_if #(.WIDTH(W)) bm ();
  piso_tx_if #(.WIDTH(W)) bl ();

  assign bm.din   = din;
  assign bm.load  = load;
  assign bm.flush = flush;
  assign bl.din   = din;
  assign bl.load  = load;
  assign bl.flush = flush;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bm)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bl)
  );

  always #5 clk = ~clk;

  // frame model: queue front is the bit on the wire this cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_m.delete();
      q_l.delete();
    end else if (q_m.size() != 0) begin
      if (flush) begin
        q_m.delete();
        q_l.delete();
      end else begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
    end else if (load) begin
      for (int k = 0; k < W; k++) begin
        q_m.push_back(din[W-1-k]);
        q_l.push_back(din[k]);
      end
      if (PAR != 0) begin
        q_m.push_back(^din);
        q_l.push_back(^din);
      end
    end
  end

  // {sout_valid, sout, done, ready, busy} for each transmitter
  function automatic logic [9:0] expv();
    logic [4:0] m;
    logic [4:0] l;
    m = 5'b00010;
    l = 5'b00010;
    if (q_m.size() != 0) begin
      m = {1'b1, q_m[0], q_m.size() == 1, 2'b01};
      l = {1'b1, q_l[0], q_l.size() == 1, 2'b01};
    end
    return {m, l};
  endfunction

  function automatic logic [9:0] obsv();
    return {bm.sout_valid, bm.sout, bm.done, bm.ready, bm.busy,
            bl.sout_valid, bl.sout, bl.done, bl.ready, bl.busy};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obsv() !== 10'b00010_00010) begin
      errors++;
      $display("FAIL reset_hold got %b want %b", obsv(), 10'b00010_00010);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obsv() !== expv()) begin
      errors++;
      $display("FAIL reset_idle got %b want %b", obsv(), expv());
    end
  endtask

  task automatic test_known_msb();
    logic [W-1:0] sm;
    logic [W-1:0] sl;
    sm = '0;
    sl = '0;
    din = 4'b1011;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i <= FL; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL known c%0d got %b want %b", i + 1, obsv(), expv());
      end
      if (i < W) begin
        sm = {sm[W-2:0], bm.sout};
        sl = {bl.sout, sl[W-1:1]};
      end
      @(negedge clk);
    end
    checks++;
    if (sm !== 4'b1011 || sl !== 4'b1011) begin
      errors++;
      $display("FAIL known_sipo got %b/%b want 1011/1011", sm, sl);
    end
  endtask

  task automatic test_lsb_ignore();
    logic [W-1:0] sl;
    sl = '0;
    din = 4'b0110;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < FL + 3; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL ignore c%0d got %b want %b", i + 1, obsv(), expv());
      end
      if (i < W) sl = {bl.sout, sl[W-1:1]};
      if (i == 1) begin
        din = 4'b1111;
        load = 1'b1;
      end
      if (i == 2) begin
        load = 1'b0;
        din = '0;
      end
      @(negedge clk);
    end
    checks++;
    if (sl !== 4'b0110) begin
      errors++;
      $display("FAIL ignore_sipo got %b want 0110", sl);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] sm;
    sm = '0;
    din = 4'b1001;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (obsv() !== expv()) begin
      errors++;
      $display("FAIL rstmid_c1 got %b want %b", obsv(), expv());
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obsv() !== 10'b00010_00010) begin
      errors++;
      $display("FAIL rstmid_async got %b want %b", obsv(), 10'b00010_00010);
    end
    @(negedge clk);
    rst = 1'b0;
    din = 4'b1001;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i <= FL; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL rstmid c%0d got %b want %b", i + 1, obsv(), expv());
      end
      if (i < W) sm = {sm[W-2:0], bm.sout};
      @(negedge clk);
    end
    checks++;
    if (sm !== 4'b1001) begin
      errors++;
      $display("FAIL rstmid_sipo got %b want 1001", sm);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    int gaps;
    dones = 0;
    gaps = 0;
    din = 4'b1100;
    load = 1'b1;
    @(negedge clk);
    din = 4'b0011;
    for (int i = 0; i <= 2 * FL; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL b2b c%0d got %b want %b", i + 1, obsv(), expv());
      end
      if (bm.done) dones++;
      if (!bm.sout_valid) gaps++;
      @(negedge clk);
    end
    load = 1'b0;
    checks++;
    if (dones != 2 || gaps != 1) begin
      errors++;
      $display("FAIL b2b_count got done=%0d gap=%0d want 2/1", dones, gaps);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flush();
    din = W'($urandom);
    load = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < FL + 5; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL flush c%0d got %b want %b", i + 1, obsv(), expv());
      end
      if (i == 3) begin
        checks++;
        if (bm.sout_valid !== 1'b0 || bm.ready !== 1'b1) begin
          errors++;
          $display("FAIL flush_idle got v=%b r=%b want 0/1",
                   bm.sout_valid, bm.ready);
        end
      end
      if (i == 4) begin
        checks++;
        if (bm.sout_valid !== 1'b1) begin
          errors++;
          $display("FAIL flush_reload got v=%b want 1", bm.sout_valid);
        end
      end
      flush = (i == 2);
      if (i == 4) load = 1'b0;
      din = W'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL rand c%0d got %b want %b", i, obsv(), expv());
      end
      load  = ($urandom % 3) != 0;
      flush = ($urandom % 12) == 0;
      rst   = ($urandom % 80) == 0;
      din   = W'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    load = 1'b0;
    flush = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_known_msb();
    test_lsb_ignore();
    test_reset_mid();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 transmits din[WIDTH-1] first, 0 transmits din[0] first.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din  input  WIDTH  parallel word to serialise.
REQ-006 load  input  1  request to capture din.
REQ-007 flush  input  1  synchronous abort of the current word.
REQ-008 ready  output  1  high when load is accepted.
REQ-009 sout  output  1  serial data bit, registered.
REQ-010 sout_valid  output  1  high in every cycle where sout carries a frame bit, registered.
REQ-011 busy  output  1  high while a frame is in flight.
REQ-012 done  output  1  one-cycle pulse coincident with the last frame bit.

Function
REQ-013 FSM states: IDLE, SHIFT, PAR (PAR exists only per REQ-027).
REQ-014 ready = 1 in IDLE only; busy = ~ready.
REQ-015 Handshake: a word is accepted on any rising edge with load=1 and ready=1. Acceptance captures din into the shift register, clears the bit counter and moves IDLE->SHIFT.
REQ-016 load while ready=0 is ignored; din changes while busy do not affect the frame.
REQ-017 Latency: first bit appears on sout, with sout_valid=1, in the cycle after acceptance.
REQ-018 Data bits follow on consecutive cycles with no gaps, WIDTH cycles total, in MSB_FIRST order.
REQ-019 Bit counter width is $clog2(WIDTH) bits, counting 0..WIDTH-1 with no wrap past WIDTH-1.
REQ-020 On counter = WIDTH-1: done=1 in that cycle; next state is IDLE, or PAR when enabled.
REQ-021 In IDLE: sout=0, sout_valid=0, done=0.
REQ-022 Back-to-back: with load held high, consecutive frames are separated by exactly one IDLE cycle (sout_valid=0).
REQ-023 flush=1 in SHIFT or PAR: next state is IDLE, sout_valid=0 next cycle, no done pulse. flush has priority over load and over the last-bit transition; flush in IDLE has no effect.
REQ-024 rst has priority over flush and load in every state.

Reset
REQ-025 While rst=1 (asynchronously): state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, done=0; hence ready=1, busy=0.
REQ-026 rst asserted mid-frame abandons the frame immediately, with no done pulse. The first accepted load after rst deasserts starts a fresh frame.

Configuration
REQ-027 Macro PISO_TX_PARITY_EN defined: after the last data bit, state PAR drives one even-parity bit (XOR of the captured word) with sout_valid=1. done moves to the PAR cycle, and the frame is WIDTH+1 cycles.
REQ-028 Macro undefined: PAR state, parity logic and parity register are absent; the frame is WIDTH cycles and done is on the last data bit.

Structure
REQ-029 Package piso_tx_pkg holds the state enum typedef (IDLE, SHIFT, PAR) and the default-width localparam.
REQ-030 Sub-module piso_tx_bitcnt (parameterised up-counter with clear, enable and terminal-count flag) is instantiated once for the bit counter.
REQ-031 State, shift register and all outputs use one asynchronous-reset always block per register group; no latches.

Verification
REQ-032 WIDTH=4, MSB_FIRST=1, din=4'b1011, load pulse -> sout 1,0,1,1 on cycles 1..4 after acceptance; done on cycle 4; a chained 4-bit serial-in shift register holds 1011 after cycle 4.
REQ-033 MSB_FIRST=0, din=4'b0110 -> sout 0,1,1,0; load pulsed in cycle 2 of the frame with din=4'b1111 -> ignored, no second frame.
REQ-034 rst asserted in cycle 2 of a frame -> sout_valid=0 and ready=1 immediately; no done pulse; the next load of 4'b1001 transmits 1,0,0,1.
REQ-035 load held high, din=4'b1100 then 4'b0011 -> two frames separated by exactly one sout_valid=0 cycle; done pulses twice.
REQ-036 flush in cycle 3 of a frame while load=1 -> IDLE next cycle, no done; the load is accepted only in the following IDLE cycle.
REQ-037 PISO_TX_PARITY_EN defined, WIDTH=8, din=8'hA7 -> 8 data bits then parity bit 1; done on cycle 9.
